// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types and constants for the instruction prefetch unit
//                (fetch entry record, prefetch control state).
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    localparam int              XLEN             = 32;
    localparam int              INSTR_BYTES      = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // One buffered instruction together with the address it was fetched from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // RUN: responses are pushed; FLUSH: stale responses are being dropped
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of fetch entries. Head is read straight
//                from registered storage; clear overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Entry storage, zeroed at reset so the head reads as zero out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch
//  Description : Instruction prefetch unit. Issues in-order word fetches under
//                a credit limit, buffers responses with their PCs and streams
//                them to IF_ID. EX redirects flush the buffer and discard the
//                responses of requests already in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch
    import if_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            out_stall
);

    localparam int              CW      = $clog2(DEPTH+1);
    localparam logic [CW:0]     CAP     = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW:0]     committed;
    logic            credit;
    logic            req_fire;
    logic            rsp_take;
    logic            push;
    logic            pop;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Every in-flight request must have a FIFO slot reserved for its response
    assign committed      = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign credit         = (committed < CAP);
    assign imem_req_valid = rst && credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored
    assign rsp_take   = imem_rsp_valid && (outstanding_q != '0);
    assign push       = rsp_take && !redirect_valid && (state_q == RUN);
    assign pop        = !fifo_empty && !out_stall && !redirect_valid;
    assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};

    assign out_valid = !fifo_empty;
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

    // Next-state for fetch/response PCs, request accounting and flush control
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        if (redirect_valid) begin
            // Everything still in flight is stale; the response arriving now is dropped
            fetch_pc_d    = redirect_pc;
            rsp_pc_d      = redirect_pc;
            outstanding_d = outstanding_q - CW'(rsp_take);
            drop_cnt_d    = outstanding_q - CW'(rsp_take);
            state_d       = (drop_cnt_d != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
            if (rsp_take) begin
                if (state_q == RUN) begin
                    rsp_pc_d = rsp_pc_q + PC_STEP;
                end else begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) begin
                        state_d = RUN;
                    end
                end
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_valid),
        .data_i  (push_entry),
        .head_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The credit limit must make a push into a full buffer impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_prefetch
//  Description : Directed/table-driven bench for if_prefetch with an in-order
//                instruction memory model of configurable response latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam logic [31:0] RDIR  = 32'h8000_0100;

    typedef struct packed {
        logic        redir;
        logic        stall;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_pc;
    } vec_t;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_stall      = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc      = 0;
    int          last_due = -1;
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic [31:0] exp_pc;
    int          pops;

    if_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_stall      (out_stall)
    );

    always #5 clk = ~clk;

    // Instruction word the memory returns for a given address
    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] a(input int n);
        return RPC + 32'(4 * n);
    endfunction

    function automatic vec_t mk(input logic redir, input logic stall, input logic rv,
                                input logic [31:0] addr, input logic ov, input logic [31:0] pc);
        return '{redir: redir, stall: stall, e_rv: rv, e_addr: addr, e_ov: ov, e_pc: pc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    task automatic reset_model();
        q_addr.delete();
        q_due.delete();
        cyc            = 0;
        last_due       = -1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        out_stall      = 1'b0;
        imem_req_ready = 1'b1;
        reset_model();
    endtask

    // One clock: record the handshake, then present the next in-order response
    task automatic step();
        bit          fire;
        bit          take;
        logic [31:0] addr;
        int          due;
        fire = imem_req_valid && imem_req_ready;
        take = imem_rsp_valid;
        addr = imem_req_addr;
        @(posedge clk);
        if (take) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (fire) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(addr);
            q_due.push_back(due);
        end
        cyc++;
        @(negedge clk);
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(q_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
    endtask

    // Scoreboard cycle: every pop must be the next sequential PC since the last redirect
    task automatic sb_cycle(input bit redir, input logic [31:0] rpc, input bit stall, input bit rdy);
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_stall      = stall;
        imem_req_ready = rdy;
        #1;
        chk("SB credit bound", 32'(q_addr.size() <= DEPTH), 32'd1);
        if (redir) begin
            exp_pc = rpc;
        end else if (out_valid && !stall) begin
            chk("SB out_pc", out_pc, exp_pc);
            chk("SB out_instr", out_instr, instr_of(exp_pc));
            exp_pc += 32'd4;
            pops++;
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[17];
        bit          rd;
        logic [31:0] tgt;

        // ready=1, latency 1; stall window then a redirect coinciding with a response
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, a(0),          1'b0, 32'h0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, a(1),          1'b0, 32'h0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, a(2),          1'b1, a(0));
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, a(3),          1'b1, a(1));
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, a(4),          1'b1, a(2));
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, a(5),          1'b1, a(2));
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, a(6),          1'b1, a(2));
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, a(6),          1'b1, a(2));
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, a(6),          1'b1, a(2));
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, a(6),          1'b1, a(3));
        tbl[10] = mk(1'b0, 1'b0, 1'b1, a(7),          1'b1, a(4));
        tbl[11] = mk(1'b0, 1'b0, 1'b1, a(8),          1'b1, a(5));
        tbl[12] = mk(1'b1, 1'b0, 1'b0, a(9),          1'b1, a(6));
        tbl[13] = mk(1'b0, 1'b0, 1'b1, RDIR,          1'b0, 32'h0);
        tbl[14] = mk(1'b0, 1'b0, 1'b1, RDIR + 32'd4,  1'b0, 32'h0);
        tbl[15] = mk(1'b0, 1'b0, 1'b1, RDIR + 32'd8,  1'b1, RDIR);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, RDIR + 32'd12, 1'b1, RDIR + 32'd4);

        // Reset state
        #2 rst = 1'b0;
        reset_model();
        #1;
        chk("reset req_valid", imem_req_valid, 32'd0);
        chk("reset req_addr",  imem_req_addr,  RPC);
        chk("reset out_valid", out_valid,      32'd0);
        chk("reset out_pc",    out_pc,         32'd0);
        chk("reset out_instr", out_instr,      32'd0);
        repeat (2) @(negedge clk);
        release_rst();

        // Table: streaming, stall back-pressure, redirect with response in the same cycle
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 17; i++) begin
            if (i > 0) step();
            redirect_valid = tbl[i].redir;
            redirect_pc    = RDIR;
            out_stall      = tbl[i].stall;
            imem_req_ready = 1'b1;
            #1;
            chk($sformatf("T%0d req_valid", i), imem_req_valid, tbl[i].e_rv);
            chk($sformatf("T%0d req_addr", i),  imem_req_addr,  tbl[i].e_addr);
            chk($sformatf("T%0d out_valid", i), out_valid,      tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("T%0d out_pc", i),    out_pc,    tbl[i].e_pc);
                chk($sformatf("T%0d out_instr", i), out_instr, instr_of(tbl[i].e_pc));
            end
        end

        // Redirect with two requests outstanding, latency 3: both responses dropped
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        release_rst();
        lat_min = 3;
        lat_max = 3;
        #1; step();
        #1; step();
        redirect_valid = 1'b1;
        redirect_pc    = RDIR;
        #1;
        chk("B redirect blocks req", imem_req_valid, 32'd0);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("B post-redirect req_valid", imem_req_valid, 32'd1);
        chk("B post-redirect req_addr",  imem_req_addr,  RDIR);
        for (int k = 4; k <= 7; k++) begin
            step();
            #1;
            if (k < 7) begin
                chk($sformatf("B c%0d out_valid", k), out_valid, 32'd0);
            end else begin
                chk("B first out_valid", out_valid, 32'd1);
                chk("B first out_pc",    out_pc,    RDIR);
                chk("B first out_instr", out_instr, instr_of(RDIR));
            end
        end

        // Reset asserted while two stale responses remain to be dropped
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        release_rst();
        lat_min   = 3;
        lat_max   = 3;
        out_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1; step();
        end
        redirect_valid = 1'b1;
        redirect_pc    = RDIR;
        #1;
        chk("D head before redirect valid", out_valid, 32'd1);
        chk("D head before redirect pc",    out_pc,    RPC);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("D flushed out_valid", out_valid, 32'd0);
        rst = 1'b0;
        reset_model();
        #1;
        chk("D async req_valid", imem_req_valid, 32'd0);
        chk("D async req_addr",  imem_req_addr,  RPC);
        chk("D async out_valid", out_valid,      32'd0);
        chk("D async out_pc",    out_pc,         32'd0);
        chk("D async out_instr", out_instr,      32'd0);
        repeat (2) @(negedge clk);
        release_rst();
        #1;
        chk("D restart req_valid", imem_req_valid, 32'd1);
        chk("D restart req_addr",  imem_req_addr,  RPC);
        step();

        // Random ready, latency 1..3, random stalls and occasional redirects
        lat_min = 1;
        lat_max = 3;
        exp_pc  = RPC;
        pops    = 0;
        for (int c = 0; c < 400; c++) begin
            rd  = (c > 10) && ($urandom_range(24, 0) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            sb_cycle(rd, tgt, $urandom_range(3, 0) == 0, $urandom_range(1, 0) == 1);
        end
        chk("R pops seen", 32'(pops > 20), 32'd1);

        // Address wrap across 0xFFFF_FFFC -> 0
        lat_min = 1;
        lat_max = 1;
        sb_cycle(1'b1, 32'hFFFF_FFF8, 1'b0, 1'b1);
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            sb_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("W pops across wrap", 32'(pops >= 4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
